counter_display_ctrl: RTL
=========================

COUNTER_DISPLAY_CTRL -- requirements
Module: counter_display_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per count step (min 2).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clk cycles per display digit slot (min 2).
REQ-003 SHALL have port clk  input  1  system clock, all state rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  synchronous single-cycle pulse: begin/resume counting.
REQ-006 SHALL have port stop  input  1  synchronous single-cycle pulse: pause counting.
REQ-007 SHALL have port clear  input  1  synchronous single-cycle pulse: zero count, return to IDLE.
REQ-008 SHALL have port up_down  input  1  1 = count up, 0 = count down, sampled on each tick.
REQ-009 SHALL have port bcd  output  16  four BCD digits, [3:0] least significant.
REQ-010 SHALL have port running  output  1  high exactly while state is RUN.
REQ-011 SHALL have port an  output  4  digit enables, active-low, one-hot-low.
REQ-012 SHALL have port seg  output  7  segments {a,b,c,d,e,f,g}, active-low.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, evaluated every clk edge.
REQ-014 SHALL apply priority clear > stop > start when several pulses coincide.
REQ-015 SHALL transition: any state + clear -> IDLE; IDLE + start -> RUN; RUN + stop -> PAUSE; PAUSE + start -> RUN; all other combinations hold state.
REQ-016 SHALL on clear set bcd to 0000 and prescaler to 0 in the same edge as the state change.
REQ-017 SHALL run prescaler 0..TICK_DIV-1 only in RUN, hold it in PAUSE, hold it at 0 in IDLE.
REQ-018 SHALL generate an internal tick when prescaler equals TICK_DIV-1 in RUN; prescaler wraps to 0 on that edge.
REQ-019 SHALL update bcd on the tick edge: first tick occurs TICK_DIV cycles after entering RUN from IDLE.
REQ-020 SHALL count decimal per digit with carry/borrow: up 0009->0010, 9999->0000; down 0010->0009, 0000->9999.
REQ-021 SHALL never hold a BCD digit value above 9.
REQ-022 SHALL discard a tick coinciding with stop (stop wins, bcd unchanged, prescaler frozen at TICK_DIV-1 and resumes to tick one cycle after re-entering RUN).
REQ-023 SHALL run a free scan counter 0..SCAN_DIV-1 in all states; at SCAN_DIV-1 it wraps and digit index advances 0,1,2,3,0.
REQ-024 SHALL register an and seg, reflecting digit index and bcd from the previous cycle (1-cycle latency).
REQ-025 SHALL drive an[i]=0 only for digit index i, others 1.
REQ-026 SHALL encode seg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-027 SHALL drive running combinationally from the state register (no extra latency).

Reset
REQ-028 SHALL on reset assertion immediately force: state IDLE, bcd 0000, prescaler 0, scan counter 0, digit index 0, an 1111, seg 1111111, running 0.
REQ-029 SHALL on reset mid-count discard any pending tick and partial prescaler count.
REQ-030 SHALL display digit 0 (an=1110, seg=0000001) on the second clk edge after reset release.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-031 SHALL cover: start pulse, up_down=1, run 40 cycles -> bcd 0x0010, running=1, ticks every 4 cycles.
REQ-032 SHALL cover: preload via 9999 ticks down from 0000 is replaced by: from 0000, up_down=0, one tick -> bcd 0x9999; then up_down=1, one tick -> 0x0000.
REQ-033 SHALL cover: stop and start asserted same cycle in RUN -> PAUSE, bcd frozen; later start -> resumes, next tick after remaining prescaler cycles.
REQ-034 SHALL cover: clear with start/stop in RUN at bcd 0x0007 -> IDLE, bcd 0x0000, running=0, no tick for following 8 cycles.
REQ-035 SHALL cover: bcd 0x1234, observe 8 cycles of scan -> an cycles 1110,1101,1011,0111 with seg 1001100,0000110,0010010,1001111.
REQ-036 SHALL cover: reset asserted asynchronously between clk edges during RUN -> outputs reach REQ-028 values before next clk edge.

Source files
------------

// File: rtl/counter_display_ctrl.sv
// counter_display_ctrl
// Four-digit BCD up/down counter with start/stop/clear control and a
// multiplexed, active-low seven-segment display driver.
//   - IDLE/RUN/PAUSE control FSM; clear > stop > start when pulses coincide.
//   - A prescaler divides clk by TICK_DIV to produce the count tick in RUN.
//   - A free-running scan counter steps the displayed digit every SCAN_DIV clks.
module counter_display_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        up_down,
  output logic [15:0] bcd,
  output logic        running,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // One decimal step of the whole 4-digit value with ripple carry/borrow.
  // Any out-of-range digit is treated as a wrap point so it can never persist.
  function automatic logic [15:0] bcd_step(input logic [15:0] val, input logic up);
    logic [15:0] res;
    logic        carry;
    logic [3:0]  d;
    res   = val;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = val[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (d >= 4'd9) begin
            res[4*i +: 4] = 4'd0;
            carry         = 1'b1;
          end else begin
            res[4*i +: 4] = d + 4'd1;
            carry         = 1'b0;
          end
        end else begin
          if ((d == 4'd0) || (d > 4'd9)) begin
            res[4*i +: 4] = 4'd9;
            carry         = 1'b1;
          end else begin
            res[4*i +: 4] = d - 4'd1;
            carry         = 1'b0;
          end
        end
      end else begin
        res[4*i +: 4] = d;
      end
    end
    return res;
  endfunction

  // Active-low segment pattern {a,b,c,d,e,f,g}; non-decimal input blanks.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [1:0]      digit_q, digit_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            tick_s;
  logic            scan_wrap_s;
  logic [3:0]      cur_digit_s;

  assign tick_s = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

  // Control FSM, prescaler and count value next-state.
  // A stop in RUN freezes the prescaler, so a coinciding tick is discarded
  // and re-fires one cycle after RUN is re-entered.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bcd_d   = bcd_q;
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      bcd_d   = 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (tick_s) begin
            presc_d = '0;
            bcd_d   = bcd_step(bcd_q, up_down);
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          bcd_d   = 16'h0000;
        end
      endcase
    end
  end

  // Display scan: free-running slot counter, digit index, registered an/seg.
  always_comb begin
    scan_wrap_s = (scan_q == SCAN_MAX);
    if (scan_wrap_s) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      scan_d  = scan_q + SW'(1);
      digit_d = digit_q;
    end
    case (digit_q)
      2'd0:    cur_digit_s = bcd_q[3:0];
      2'd1:    cur_digit_s = bcd_q[7:4];
      2'd2:    cur_digit_s = bcd_q[11:8];
      2'd3:    cur_digit_s = bcd_q[15:12];
      default: cur_digit_s = 4'd0;
    endcase
    an_d  = ~(4'b0001 << digit_q);
    seg_d = seg_encode(cur_digit_s);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      bcd_q   <= 16'h0000;
      scan_q  <= '0;
      digit_q <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      scan_q  <= scan_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd     = bcd_q;
  assign running = (state_q == ST_RUN);
  assign an      = an_q;
  assign seg     = seg_q;

endmodule
